// File: rtl/cellfifo_cell_reader_if.sv
// Read-side bundle for cellfifo_cell_reader: FIFO read port plus the
// valid/ready output stream. The reader is the master; the FIFO and
// downstream consumer together form the slave side.
interface cellfifo_cell_reader_if #(
  parameter int DATA_SIZE = 36
);
  logic                 rd_rdy;
  logic                 rd_req;
  logic                 rd_vld;
  logic                 rd_eoc;
  logic [DATA_SIZE-1:0] rd_data;
  logic                 m_vld;
  logic                 m_rdy;
  logic [DATA_SIZE-1:0] m_data;
  logic                 m_last;

  modport master (
    input  rd_rdy, rd_vld, rd_eoc, rd_data, m_rdy,
    output rd_req, m_vld, m_data, m_last
  );

  modport slave (
    output rd_rdy, rd_vld, rd_eoc, rd_data, m_rdy,
    input  rd_req, m_vld, m_data, m_last
  );
endinterface

// File: rtl/cellfifo_cell_reader.sv
// cellfifo_cell_reader: drains complete cells from a cell FIFO read port and
// re-emits them as a valid/ready stream with a per-cell last flag. A 2-entry
// output buffer absorbs backpressure; cells longer than MAX_LEN are truncated
// (last forced, len_err pulsed) and their remainder is flushed.
// Optional build macro: CELL_READER_STAT_EN enables the cell/beat counters.
module cellfifo_cell_reader #(
  parameter int DATA_SIZE = 36,
  parameter int MAX_LEN   = 16,
  parameter int GAP_CYC   = 0,
  parameter int CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  cellfifo_cell_reader_if.master bus,
  output logic                  busy,
  output logic                  len_err,
  output logic [CNT_W-1:0]      cell_cnt,
  output logic [CNT_W-1:0]      beat_cnt
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {IDLE, READ, FLUSH, GAP} state_t;

  state_t               state, state_nxt;
  logic [LEN_W-1:0]     len, len_nxt;
  logic [7:0]           gap_cnt, gap_cnt_nxt;
  logic                 rd_req;
  logic                 push;
  logic                 push_last;
  logic                 pop;
  logic [1:0]           buf_cnt;
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [DATA_SIZE-1:0] buf_data [2];
  logic                 buf_last [2];
  logic                 m_vld;

  // Next-state and read-side control; len_err is a same-cycle pulse on the
  // beat that hits MAX_LEN without an end-of-cell.
  always_comb begin
    state_nxt   = state;
    len_nxt     = len;
    gap_cnt_nxt = gap_cnt;
    rd_req      = 1'b0;
    push        = 1'b0;
    push_last   = 1'b0;
    len_err     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.rd_rdy) state_nxt = READ;
      end
      READ: begin
        rd_req = (buf_cnt < 2'd2);
        if (rd_req && bus.rd_vld) begin
          push    = 1'b1;
          len_nxt = len + 1'b1;
          if (bus.rd_eoc) begin
            push_last   = 1'b1;
            len_nxt     = '0;
            gap_cnt_nxt = '0;
            state_nxt   = (GAP_CYC > 0) ? GAP : IDLE;
          end else if (len == LEN_W'(MAX_LEN - 1)) begin
            push_last = 1'b1;
            len_err   = 1'b1;
            len_nxt   = '0;
            state_nxt = FLUSH;
          end
        end
      end
      FLUSH: begin
        rd_req = 1'b1;
        if (bus.rd_vld && bus.rd_eoc) begin
          gap_cnt_nxt = '0;
          state_nxt   = (GAP_CYC > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_cnt == 8'(GAP_CYC - 1)) state_nxt = IDLE;
        else                            gap_cnt_nxt = gap_cnt + 8'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state, cell length and gap counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      len     <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      len     <= len_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

  assign m_vld = (buf_cnt != 2'd0);
  assign pop   = m_vld && bus.m_rdy;

  // Output buffer occupancy and pointers; push+pop together leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_cnt <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   buf_cnt <= buf_cnt + 2'd1;
        2'b01:   buf_cnt <= buf_cnt - 2'd1;
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

  // Buffer storage; contents are only observed while the entry is occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr] <= bus.rd_data;
      buf_last[wr_ptr] <= push_last;
    end
  end

  // Head entry is gated so the stream reads as zero whenever it is empty.
  assign bus.rd_req = rd_req;
  assign bus.m_vld  = m_vld;
  assign bus.m_data = m_vld ? buf_data[rd_ptr] : '0;
  assign bus.m_last = m_vld & buf_last[rd_ptr];
  assign busy       = (state != IDLE);

`ifdef CELL_READER_STAT_EN
  // Statistics: count every popped beat and every popped last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cell_cnt <= '0;
      beat_cnt <= '0;
    end else if (pop) begin
      beat_cnt <= beat_cnt + 1'b1;
      if (bus.m_last) cell_cnt <= cell_cnt + 1'b1;
    end
  end
`else
  assign cell_cnt = '0;
  assign beat_cnt = '0;
`endif
endmodule

// File: tb/tb_cellfifo_cell_reader.sv
// Directed testbench for cellfifo_cell_reader (MAX_LEN=16, GAP_CYC=2).
// A queue models the cell FIFO; output beats are collected and compared
// against hand-written expected sequences.
module tb_cellfifo_cell_reader;
  localparam int DW = 36;
  localparam int ML = 16;
  localparam int GC = 2;
  localparam int CW = 16;
`ifdef CELL_READER_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          busy;
  logic          len_err;
  logic [CW-1:0] cell_cnt;
  logic [CW-1:0] beat_cnt;

  cellfifo_cell_reader_if #(.DATA_SIZE(DW)) bus ();

  cellfifo_cell_reader #(
    .DATA_SIZE(DW), .MAX_LEN(ML), .GAP_CYC(GC), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .len_err(len_err),
    .cell_cnt(cell_cnt), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 0;  // 0: m_rdy high, 1: toggle, 2: m_rdy low
  logic [DW:0]   src_q [$];
  logic [DW-1:0] got_data [$];
  logic          got_last [$];
  int            got_cyc [$];
  int            read_cyc [$];
  int reads, pops, lerr_cnt, max_occ;
  logic req_now;

  task automatic clear_model();
    src_q.delete(); got_data.delete(); got_last.delete();
    got_cyc.delete(); read_cyc.delete();
    reads = 0; pops = 0; lerr_cnt = 0; max_occ = 0; req_now = 1'b0;
  endtask

  task automatic drive_idle();
    bus.rd_rdy = 1'b0; bus.rd_vld = 1'b0; bus.rd_eoc = 1'b0;
    bus.rd_data = '0; bus.m_rdy = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_model();
  endtask

  // One clock: drive FIFO/consumer inputs for this cycle, then sample outputs.
  task automatic cycle();
    logic has_cell;
    @(posedge clk); #1;
    cyc++;
    case (rdy_mode)
      0:       bus.m_rdy = 1'b1;
      1:       bus.m_rdy = ~bus.m_rdy;
      default: bus.m_rdy = 1'b0;
    endcase
    has_cell = 1'b0;
    foreach (src_q[i]) if (src_q[i][DW]) has_cell = 1'b1;
    bus.rd_rdy = has_cell;
    req_now = bus.rd_req;
    if (bus.rd_req && src_q.size() > 0) begin
      {bus.rd_eoc, bus.rd_data} = src_q.pop_front();
      bus.rd_vld = 1'b1;
      reads++;
      read_cyc.push_back(cyc);
    end else begin
      bus.rd_vld = 1'b0; bus.rd_eoc = 1'b0; bus.rd_data = '0;
    end
    #1;
    if (len_err) lerr_cnt++;
    if (bus.m_vld && bus.m_rdy) begin
      got_data.push_back(bus.m_data);
      got_last.push_back(bus.m_last);
      got_cyc.push_back(cyc);
      pops++;
    end
    if (reads - pops > max_occ) max_occ = reads - pops;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    @(posedge clk); #1;
    checks++; if (bus.rd_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req got %b exp 0", bus.rd_req); end
    checks++; if (bus.m_vld !== 1'b0) begin errors++; $display("FAIL reset_m_vld got %b exp 0", bus.m_vld); end
    checks++; if (bus.m_data !== '0) begin errors++; $display("FAIL reset_m_data got %h exp 0", bus.m_data); end
    checks++; if (bus.m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last got %b exp 0", bus.m_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL reset_len_err got %b exp 0", len_err); end
    checks++; if (cell_cnt !== '0) begin errors++; $display("FAIL reset_cell_cnt got %0d exp 0", cell_cnt); end
    checks++; if (beat_cnt !== '0) begin errors++; $display("FAIL reset_beat_cnt got %0d exp 0", beat_cnt); end
    #1 rst = 1'b0;
  endtask

  task automatic test_single_cell();
    logic [DW-1:0] d;
    logic l;
    int c;
    do_reset();
    rdy_mode = 0;
    for (int i = 0; i < 4; i++) src_q.push_back({1'(i == 3), DW'(32'hA0 + i)});
    run(12);
    checks++; if (got_data.size() !== 4) begin errors++; $display("FAIL single_count got %0d exp 4", got_data.size()); end
    for (int i = 0; i < 4; i++) begin
      d = (i < got_data.size()) ? got_data[i] : 'x;
      l = (i < got_last.size()) ? got_last[i] : 1'bx;
      c = (i < got_cyc.size()) ? got_cyc[i] : -1;
      checks++; if (d !== DW'(32'hA0 + i)) begin errors++; $display("FAIL single_data[%0d] got %h exp %h", i, d, 32'hA0 + i); end
      checks++; if (l !== 1'(i == 3)) begin errors++; $display("FAIL single_last[%0d] got %b exp %b", i, l, i == 3); end
      checks++; if (c !== read_cyc[0] + 1 + i) begin errors++; $display("FAIL single_cycle[%0d] got %0d exp %0d", i, c, read_cyc[0] + 1 + i); end
    end
    checks++; if (cell_cnt !== CW'(STAT ? 1 : 0)) begin errors++; $display("FAIL single_cell_cnt got %0d exp %0d", cell_cnt, STAT ? 1 : 0); end
    checks++; if (beat_cnt !== CW'(STAT ? 4 : 0)) begin errors++; $display("FAIL single_beat_cnt got %0d exp %0d", beat_cnt, STAT ? 4 : 0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b exp 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d;
    logic l;
    int gap;
    do_reset();
    rdy_mode = 0;
    for (int i = 0; i < 3; i++) src_q.push_back({1'(i == 2), DW'(32'hB0 + i)});
    for (int i = 0; i < 3; i++) src_q.push_back({1'(i == 2), DW'(32'hC0 + i)});
    run(24);
    checks++; if (got_data.size() !== 6) begin errors++; $display("FAIL b2b_count got %0d exp 6", got_data.size()); end
    for (int i = 0; i < 6; i++) begin
      d = (i < got_data.size()) ? got_data[i] : 'x;
      l = (i < got_last.size()) ? got_last[i] : 1'bx;
      checks++; if (d !== DW'((i < 3) ? (32'hB0 + i) : (32'hC0 + i - 3))) begin errors++; $display("FAIL b2b_data[%0d] got %h", i, d); end
      checks++; if (l !== 1'(i == 2 || i == 5)) begin errors++; $display("FAIL b2b_last[%0d] got %b exp %b", i, l, i == 2 || i == 5); end
    end
    gap = (read_cyc.size() >= 4) ? (read_cyc[3] - read_cyc[2] - 1) : -1;
    checks++; if (gap !== 3) begin errors++; $display("FAIL b2b_req_gap got %0d exp 3", gap); end
    checks++; if (cell_cnt !== CW'(STAT ? 2 : 0)) begin errors++; $display("FAIL b2b_cell_cnt got %0d exp %0d", cell_cnt, STAT ? 2 : 0); end
    checks++; if (beat_cnt !== CW'(STAT ? 6 : 0)) begin errors++; $display("FAIL b2b_beat_cnt got %0d exp %0d", beat_cnt, STAT ? 6 : 0); end
  endtask

  task automatic test_toggle_ready();
    logic [DW-1:0] d;
    logic l;
    do_reset();
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) src_q.push_back({1'(i == 7), DW'(32'hD0 + i)});
    run(40);
    checks++; if (got_data.size() !== 8) begin errors++; $display("FAIL toggle_count got %0d exp 8", got_data.size()); end
    for (int i = 0; i < 8; i++) begin
      d = (i < got_data.size()) ? got_data[i] : 'x;
      l = (i < got_last.size()) ? got_last[i] : 1'bx;
      checks++; if (d !== DW'(32'hD0 + i)) begin errors++; $display("FAIL toggle_data[%0d] got %h exp %h", i, d, 32'hD0 + i); end
      checks++; if (l !== 1'(i == 7)) begin errors++; $display("FAIL toggle_last[%0d] got %b exp %b", i, l, i == 7); end
    end
    checks++; if (max_occ > 2) begin errors++; $display("FAIL toggle_occupancy got %0d exp <=2", max_occ); end
  endtask

  task automatic test_stall_release();
    logic [DW-1:0] d;
    do_reset();
    rdy_mode = 2;
    for (int i = 0; i < 4; i++) src_q.push_back({1'(i == 3), DW'(32'hF0 + i)});
    run(8);
    checks++; if (reads !== 2) begin errors++; $display("FAIL stall_reads got %0d exp 2", reads); end
    checks++; if (req_now !== 1'b0) begin errors++; $display("FAIL stall_rd_req got %b exp 0", req_now); end
    checks++; if (bus.m_vld !== 1'b1) begin errors++; $display("FAIL stall_m_vld got %b exp 1", bus.m_vld); end
    checks++; if (bus.m_data !== DW'(32'hF0)) begin errors++; $display("FAIL stall_head got %h exp f0", bus.m_data); end
    rdy_mode = 0;
    cycle();
    rdy_mode = 2;
    cycle();
    checks++; if (req_now !== 1'b1) begin errors++; $display("FAIL stall_req_return got %b exp 1", req_now); end
    rdy_mode = 0;
    run(10);
    checks++; if (got_data.size() !== 4) begin errors++; $display("FAIL stall_count got %0d exp 4", got_data.size()); end
    for (int i = 0; i < 4; i++) begin
      d = (i < got_data.size()) ? got_data[i] : 'x;
      checks++; if (d !== DW'(32'hF0 + i)) begin errors++; $display("FAIL stall_data[%0d] got %h exp %h", i, d, 32'hF0 + i); end
    end
  endtask

  task automatic test_overlength();
    logic [DW-1:0] d;
    logic l;
    do_reset();
    rdy_mode = 0;
    for (int i = 0; i < 20; i++) src_q.push_back({1'(i == 19), DW'(32'h100 + i)});
    run(45);
    checks++; if (got_data.size() !== ML) begin errors++; $display("FAIL ovl_count got %0d exp %0d", got_data.size(), ML); end
    for (int i = 0; i < ML; i++) begin
      d = (i < got_data.size()) ? got_data[i] : 'x;
      l = (i < got_last.size()) ? got_last[i] : 1'bx;
      checks++; if (d !== DW'(32'h100 + i)) begin errors++; $display("FAIL ovl_data[%0d] got %h exp %h", i, d, 32'h100 + i); end
      checks++; if (l !== 1'(i == ML - 1)) begin errors++; $display("FAIL ovl_last[%0d] got %b exp %b", i, l, i == ML - 1); end
    end
    checks++; if (lerr_cnt !== 1) begin errors++; $display("FAIL ovl_len_err_pulses got %0d exp 1", lerr_cnt); end
    checks++; if (reads !== 20) begin errors++; $display("FAIL ovl_reads got %0d exp 20", reads); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovl_busy_end got %b exp 0", busy); end
    checks++; if (cell_cnt !== CW'(STAT ? 1 : 0)) begin errors++; $display("FAIL ovl_cell_cnt got %0d exp %0d", cell_cnt, STAT ? 1 : 0); end
    checks++; if (beat_cnt !== CW'(STAT ? 16 : 0)) begin errors++; $display("FAIL ovl_beat_cnt got %0d exp %0d", beat_cnt, STAT ? 16 : 0); end
  endtask

  task automatic test_reset_mid_cell();
    do_reset();
    rdy_mode = 2;
    for (int i = 0; i < 5; i++) src_q.push_back({1'(i == 4), DW'(32'h50 + i)});
    run(4);
    checks++; if (reads !== 2) begin errors++; $display("FAIL midrst_reads got %0d exp 2", reads); end
    checks++; if (bus.m_vld !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL midrst_pre got m_vld=%b busy=%b exp 1 1", bus.m_vld, busy); end
    rst = 1'b1;
    #1;
    checks++; if (bus.rd_req !== 1'b0) begin errors++; $display("FAIL midrst_rd_req got %b exp 0", bus.rd_req); end
    checks++; if (bus.m_vld !== 1'b0) begin errors++; $display("FAIL midrst_m_vld got %b exp 0", bus.m_vld); end
    checks++; if (bus.m_data !== '0) begin errors++; $display("FAIL midrst_m_data got %h exp 0", bus.m_data); end
    checks++; if (bus.m_last !== 1'b0) begin errors++; $display("FAIL midrst_m_last got %b exp 0", bus.m_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
    checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL midrst_len_err got %b exp 0", len_err); end
    src_q.delete();
    drive_idle();
    @(posedge clk); #1 rst = 1'b0;
    run(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle_after got %b exp 0", busy); end
    checks++; if (bus.m_vld !== 1'b0) begin errors++; $display("FAIL midrst_m_vld_after got %b exp 0", bus.m_vld); end
  endtask

  initial begin
    drive_idle();
    clear_model();
    test_reset();
    test_single_cell();
    test_back_to_back();
    test_toggle_ready();
    test_stall_release();
    test_overlength();
    test_reset_mid_cell();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cellfifo_cell_reader.md
# cellfifo_cell_reader

Drains whole cells from the read port of a cell FIFO and re-emits them as a valid/ready stream with a per-cell last flag. It sits directly behind the FIFO read side, in the FIFO read clock domain. It starts a cell only when the FIFO reports a complete cell, and absorbs downstream backpressure through a 2-entry output buffer. It also guards against over-length cells.

## Interface
Parameters:
- DATA_SIZE, 36, width of rd_data / m_data
- MAX_LEN, 16, maximum beats per cell; must be ≥ 2
- GAP_CYC, 0, idle cycles inserted after each cell's last beat is read (0–255)
- CNT_W, 16, width of statistics counters

Ports (single clock `clk`; reset `rst` is asynchronous and active-high):
- clk  in  1  clock
- rst  in  1  asynchronous reset, active high
- rd_rdy  in  1  FIFO holds at least one complete cell
- rd_req  out  1  read request to FIFO; combinational
- rd_vld  in  1  FIFO data valid, same cycle as rd_req
- rd_eoc  in  1  FIFO end of cell, qualified by rd_vld
- rd_data  in  DATA_SIZE  FIFO read data
- m_vld  out  1  output beat valid
- m_rdy  in  1  downstream ready
- m_data  out  DATA_SIZE  output beat data
- m_last  out  1  last beat of cell (true eoc, or forced at MAX_LEN)
- busy  out  1  state ≠ IDLE
- len_err  out  1  one-cycle pulse: cell reached MAX_LEN beats without eoc
- cell_cnt  out  CNT_W  cells emitted (statistics build only)
- beat_cnt  out  CNT_W  beats emitted (statistics build only)

## Operation
- FSM states: IDLE, READ, FLUSH, GAP.
- IDLE → READ when rd_rdy = 1 (registered; rd_req first asserts the cycle after rd_rdy is sampled).
- READ: rd_req = 1 while buf_cnt < 2, where buf_cnt is the registered occupancy, not counting a same-cycle pop.
  - Each rd_vld pushes {rd_data, m_last} into the buffer and increments len (width clog2(MAX_LEN+1)).
  - rd_vld & rd_eoc: push with m_last = 1, clear len, then go to GAP if GAP_CYC > 0, else IDLE.
  - rd_vld & !rd_eoc & len == MAX_LEN−1: push with m_last = 1, pulse len_err, clear len, go to FLUSH.
  - rd_req = 1 & rd_vld = 0: no push, stay in READ (tolerated stall).
- FLUSH: rd_req = 1 unconditionally. Beats are discarded (no push). On rd_vld & rd_eoc, go to GAP or IDLE as above.
- GAP: count GAP_CYC cycles with rd_req = 0, then go to IDLE.
- Output buffer: 2-entry FIFO.
  - m_vld = buf_cnt ≠ 0; m_data/m_last are taken from the head entry.
  - Pop on m_vld & m_rdy.
  - Simultaneous push and pop: buf_cnt unchanged; order is preserved.
- rd_rdy is ignored outside IDLE.
- The FIFO must deassert rd_rdy by the cycle after the final eoc if no complete cell remains.

## Timing
- Reset values: rd_req 0, m_vld 0, m_data 0, m_last 0, busy 0, len_err 0, cell_cnt 0, beat_cnt 0; state IDLE; buf_cnt 0; len 0.
- Latency: rd_vld in cycle N → m_vld in cycle N+1 (when the buffer was empty).
- Throughput: 1 beat/cycle within a cell with m_rdy held high. Minimum inter-cell bubble is 1 + GAP_CYC cycles on the read side.
- Backpressure: with m_rdy = 0, at most 2 beats are read before rd_req drops. rd_req returns in the cycle after the first pop.
- Reset mid-cell: all state is cleared immediately and the partial output is lost. The FIFO read side must be reset together with this block.

## Configuration
- CELL_READER_STAT_EN defined: cell_cnt increments on each pop with m_last = 1, and beat_cnt increments on each pop. Both wrap at 2^CNT_W.
- Not defined: cell_cnt and beat_cnt are tied to 0 and no counter logic is built.

## Test plan
- 4-beat cell 0xA0..0xA3 with eoc on 0xA3, m_rdy = 1 → m_data A0..A3 on consecutive cycles starting 1 cycle after the first rd_vld; m_last only on A3; cell_cnt = 1, beat_cnt = 4.
- Two back-to-back 3-beat cells, GAP_CYC = 2 → rd_req low for exactly 3 cycles between cells; output order preserved; cell_cnt = 2.
- 8-beat cell with m_rdy toggling 1/0 every cycle → exactly 8 beats out in order; buf_cnt never exceeds 2; no beat lost or duplicated.
- MAX_LEN = 16, 20-beat cell → 16 beats out with m_last on beat 16; len_err pulses once; beats 17–20 are read and discarded; FSM returns to IDLE.
- rst asserted in READ after 2 of 5 beats → all outputs return to reset values in the same cycle; state IDLE after deassertion.
- Build without CELL_READER_STAT_EN, run scenario 1 → cell_cnt = beat_cnt = 0; stream identical.
